control_fsm: RTL and testbench

Parametrised multicycle control unit for the RISC-V datapath. It sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and latches the decoded control word for the whole instruction. It gates memory and register-file strobes to the phase that uses them, stalls on a memory-ready handshake with a timeout, and counts retired instructions. It sits between the instruction register and the datapath muxes, ALU control and memories.

---
 rtl/control_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_control_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multicycle RISC-V control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with a latched control word.
// Latency: bne 3, R/I 4, sb 4, lb 5, illegal 2 cycles; each memory not-ready cycle adds one.
// Backpressure: stalls in FETCH/MEMORY until memReady; abandons the instruction and sets fault after TIMEOUT not-ready cycles.
//
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   opcode                : instruction-register opcode, sampled only in DECODE
//   memReady              : memory completes the current access this cycle
//   fetch, irWrite        : instruction-memory request / IR load (FETCH)
//   branch                : bne compare/select (EXECUTE only)
//   memRead, memWrite     : data-memory strobes (MEMORY only)
//   memtoReg, aluOp, aluSrc : datapath selects, held EXECUTE..end of instruction
//   regWrite              : register-file write (WRITEBACK only)
//   illegal, retire       : unrecognised-opcode pulse / instruction-complete pulse
//   fault, instrCount     : sticky timeout flag / retired-instruction count
module control_fsm #(
    parameter int OPCODE_W = 7,
    parameter int ALUOP_W  = 2,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                memReady,
    output logic                fetch,
    output logic                irWrite,
    output logic                branch,
    output logic                memRead,
    output logic                memWrite,
    output logic                memtoReg,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                aluSrc,
    output logic                regWrite,
    output logic                illegal,
    output logic                retire,
    output logic                fault,
    output logic [CNT_W-1:0]    instrCount
);

    localparam logic [2:0] FETCH     = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEMORY    = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;

    localparam logic [OPCODE_W-1:0] OP_LB  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_IMM = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_SB  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(7'b1100011);

    // The counter only has to reach TIMEOUT-1 before the abandon fires.
    localparam int               WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit               TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic               branch;
        logic               memRead;
        logic               memtoReg;
        logic [ALUOP_W-1:0] aluOp;
        logic               memWrite;
        logic               aluSrc;
        logic               regWrite;
    } ctrlWord_t;

    logic [2:0]        state;
    logic [2:0]        nextState;
    ctrlWord_t         word;
    ctrlWord_t         decoded;
    logic              legal;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] nextWait;
    logic              waiting;
    logic              timeoutHit;
    logic              retireInt;
    logic              faultQ;
    logic [CNT_W-1:0]  countQ;
    logic              active;
    logic              holdPhase;

    // Opcode decode; only captured on the DECODE edge.
    always_comb begin
        decoded = '0;
        legal   = 1'b1;
        case (opcode)
            OP_LB: begin
                decoded.memRead  = 1'b1;
                decoded.memtoReg = 1'b1;
                decoded.aluOp    = ALUOP_W'(2'b00);
                decoded.aluSrc   = 1'b1;
                decoded.regWrite = 1'b1;
            end
            OP_IMM: begin
                decoded.aluOp    = ALUOP_W'(2'b10);
                decoded.aluSrc   = 1'b1;
                decoded.regWrite = 1'b1;
            end
            OP_SB: begin
                decoded.aluOp    = ALUOP_W'(2'b00);
                decoded.memWrite = 1'b1;
                decoded.aluSrc   = 1'b1;
            end
            OP_R: begin
                decoded.aluOp    = ALUOP_W'(2'b10);
                decoded.regWrite = 1'b1;
            end
            OP_BNE: begin
                decoded.branch   = 1'b1;
                decoded.aluOp    = ALUOP_W'(2'b01);
            end
            default: legal = 1'b0;
        endcase
    end

    assign waiting    = ((state == FETCH) || (state == MEMORY)) && !memReady;
    assign timeoutHit = TIMEOUT_EN && waiting && (waitCnt == WAIT_LIMIT);

    // The wait counter defaults to zero so every state transition clears it;
    // it only accumulates while a FETCH/MEMORY access is stalled.
    always_comb begin
        nextState = state;
        nextWait  = '0;
        case (state)
            FETCH: begin
                if (memReady) begin
                    nextState = DECODE;
                end else if (timeoutHit) begin
                    nextState = FETCH;
                end else if (TIMEOUT_EN) begin
                    nextWait = waitCnt + WAIT_W'(1);
                end
            end
            DECODE: begin
                nextState = legal ? EXECUTE : FETCH;
            end
            EXECUTE: begin
                if (word.branch) begin
                    nextState = FETCH;
                end else if (word.memRead || word.memWrite) begin
                    nextState = MEMORY;
                end else begin
                    nextState = WRITEBACK;
                end
            end
            MEMORY: begin
                if (memReady) begin
                    nextState = word.memWrite ? FETCH : WRITEBACK;
                end else if (timeoutHit) begin
                    nextState = FETCH;
                end else if (TIMEOUT_EN) begin
                    nextWait = waitCnt + WAIT_W'(1);
                end
            end
            WRITEBACK: begin
                nextState = FETCH;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

    // Final cycle of each legal instruction: bne EXECUTE, sb MEMORY on ready, or WRITEBACK.
    assign retireInt = ((state == EXECUTE) && word.branch) ||
                       ((state == MEMORY) && memReady && word.memWrite) ||
                       (state == WRITEBACK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FETCH;
            word    <= '0;
            waitCnt <= '0;
            faultQ  <= 1'b0;
            countQ  <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWait;
            if (state == DECODE) begin
                word <= decoded;
            end
            if (timeoutHit) begin
                faultQ <= 1'b1;
            end
            if (retireInt) begin
                countQ <= countQ + CNT_W'(1);
            end
        end
    end

    // Every output, including the registered status, reads as 0 while reset is held.
    assign active    = !reset;
    assign holdPhase = (state == EXECUTE) || (state == MEMORY) || (state == WRITEBACK);

    assign fetch      = active && (state == FETCH);
    assign irWrite    = active && (state == FETCH) && memReady;
    assign branch     = active && (state == EXECUTE) && word.branch;
    assign memRead    = active && (state == MEMORY) && word.memRead;
    assign memWrite   = active && (state == MEMORY) && word.memWrite;
    assign memtoReg   = active && holdPhase && word.memtoReg;
    assign aluOp      = (active && holdPhase) ? word.aluOp : '0;
    assign aluSrc     = active && holdPhase && word.aluSrc;
    assign regWrite   = active && (state == WRITEBACK) && word.regWrite;
    assign illegal    = active && (state == DECODE) && !legal;
    assign retire     = active && retireInt;
    assign fault      = active && faultQ;
    assign instrCount = active ? countQ : '0;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

    logic       clock;
    logic       reset;
    logic [6:0] opcode;
    logic       memReady;
    logic       fetch;
    logic       irWrite;
    logic       branch;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       regWrite;
    logic       illegal;
    logic       retire;
    logic       fault;
    logic [1:0] instrCount;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] LB   = 7'b0000011;
    localparam logic [6:0] ORI  = 7'b0010011;
    localparam logic [6:0] SB   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] BNE  = 7'b1100011;
    localparam logic [6:0] JUNK = 7'b1111111;

    control_fsm #(
        .OPCODE_W(7),
        .ALUOP_W (2),
        .TIMEOUT (4),
        .CNT_W   (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .opcode    (opcode),
        .memReady  (memReady),
        .fetch     (fetch),
        .irWrite   (irWrite),
        .branch    (branch),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .memtoReg  (memtoReg),
        .aluOp     (aluOp),
        .aluSrc    (aluSrc),
        .regWrite  (regWrite),
        .illegal   (illegal),
        .retire    (retire),
        .fault     (fault),
        .instrCount(instrCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [12:0] outVec;
    assign outVec = {fetch, irWrite, branch, memRead, memWrite, memtoReg,
                     aluOp, aluSrc, regWrite, illegal, retire, fault};

    function automatic logic [12:0] ev(input logic f, ir, br, mr, mw, m2r,
                                       input logic [1:0] aop,
                                       input logic as, rw, il, rt, ft);
        return {f, ir, br, mr, mw, m2r, aop, as, rw, il, rt, ft};
    endfunction

    // Called #1 after a rising edge with inputs already driven; samples at the
    // falling edge, then moves to #1 after the next rising edge.
    task automatic expectCycle(input string tag, input logic [12:0] exp, input logic [1:0] expCnt);
        #4;
        checks++;
        assert (outVec === exp) else begin
            errors++;
            $error("FAIL %s outputs: observed %b expected %b", tag, outVec, exp);
        end
        checks++;
        assert (instrCount === expCnt) else begin
            errors++;
            $error("FAIL %s instrCount: observed %0d expected %0d", tag, instrCount, expCnt);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        memReady = 1'b1;
        opcode   = JUNK;
        @(posedge clock);
        #1;
        expectCycle("reset_hold", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd0);
        reset = 1'b0;

        // R-type, memReady high: 4 cycles
        opcode = 7'b0;
        expectCycle("r_fetch",  ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd0);
        opcode = RT;
        expectCycle("r_decode", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd0);
        opcode = JUNK;
        expectCycle("r_exec",   ev(0,0,0,0,0,0,2'b10,0,0,0,0,0), 2'd0);
        expectCycle("r_wb",     ev(0,0,0,0,0,0,2'b10,0,1,0,1,0), 2'd0);

        // lb with two not-ready MEMORY cycles: 7 cycles
        expectCycle("lb_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd1);
        opcode = LB;
        expectCycle("lb_decode", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd1);
        opcode = JUNK;
        expectCycle("lb_exec",  ev(0,0,0,0,0,1,2'b00,1,0,0,0,0), 2'd1);
        memReady = 1'b0;
        expectCycle("lb_mem1",  ev(0,0,0,1,0,1,2'b00,1,0,0,0,0), 2'd1);
        expectCycle("lb_mem2",  ev(0,0,0,1,0,1,2'b00,1,0,0,0,0), 2'd1);
        memReady = 1'b1;
        expectCycle("lb_mem3",  ev(0,0,0,1,0,1,2'b00,1,0,0,0,0), 2'd1);
        expectCycle("lb_wb",    ev(0,0,0,0,0,1,2'b00,1,1,0,1,0), 2'd1);

        // sb, bne, ori back to back: count 3, wraps to 0, then 1
        expectCycle("sb_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd2);
        opcode = SB;
        expectCycle("sb_decode", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd2);
        opcode = JUNK;
        expectCycle("sb_exec",  ev(0,0,0,0,0,0,2'b00,1,0,0,0,0), 2'd2);
        expectCycle("sb_mem",   ev(0,0,0,0,1,0,2'b00,1,0,0,1,0), 2'd2);
        expectCycle("bne_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd3);
        opcode = BNE;
        expectCycle("bne_decode", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd3);
        opcode = JUNK;
        expectCycle("bne_exec", ev(0,0,1,0,0,0,2'b01,0,0,0,1,0), 2'd3);
        expectCycle("ori_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd0);
        opcode = ORI;
        expectCycle("ori_decode", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd0);
        opcode = JUNK;
        expectCycle("ori_exec", ev(0,0,0,0,0,0,2'b10,1,0,0,0,0), 2'd0);
        expectCycle("ori_wb",   ev(0,0,0,0,0,0,2'b10,1,1,0,1,0), 2'd0);

        // illegal opcode after one stalled FETCH cycle
        memReady = 1'b0;
        expectCycle("ill_fetch_wait", ev(1,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd1);
        memReady = 1'b1;
        expectCycle("ill_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd1);
        opcode = JUNK;
        expectCycle("ill_decode", ev(0,0,0,0,0,0,2'b00,0,0,1,0,0), 2'd1);

        // sb times out in MEMORY after 4 not-ready cycles
        opcode = 7'b0;
        expectCycle("to_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd1);
        opcode = SB;
        expectCycle("to_decode", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd1);
        opcode = JUNK;
        expectCycle("to_exec",  ev(0,0,0,0,0,0,2'b00,1,0,0,0,0), 2'd1);
        memReady = 1'b0;
        expectCycle("to_mem1",  ev(0,0,0,0,1,0,2'b00,1,0,0,0,0), 2'd1);
        expectCycle("to_mem2",  ev(0,0,0,0,1,0,2'b00,1,0,0,0,0), 2'd1);
        expectCycle("to_mem3",  ev(0,0,0,0,1,0,2'b00,1,0,0,0,0), 2'd1);
        expectCycle("to_mem4",  ev(0,0,0,0,1,0,2'b00,1,0,0,0,0), 2'd1);
        expectCycle("to_fault_fetch", ev(1,0,0,0,0,0,2'b00,0,0,0,0,1), 2'd1);

        // R-type interrupted by reset in EXECUTE; fault stays set until then
        memReady = 1'b1;
        expectCycle("rst_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,1), 2'd1);
        opcode = RT;
        expectCycle("rst_decode", ev(0,0,0,0,0,0,2'b00,0,0,0,0,1), 2'd1);
        opcode = JUNK;
        reset = 1'b1;
        expectCycle("rst_in_exec", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd0);
        reset = 1'b0;

        // sb with memReady arriving on the 4th MEMORY cycle: no fault
        opcode = 7'b0;
        expectCycle("rdy_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd0);
        opcode = SB;
        expectCycle("rdy_decode", ev(0,0,0,0,0,0,2'b00,0,0,0,0,0), 2'd0);
        opcode = JUNK;
        expectCycle("rdy_exec", ev(0,0,0,0,0,0,2'b00,1,0,0,0,0), 2'd0);
        memReady = 1'b0;
        expectCycle("rdy_mem1", ev(0,0,0,0,1,0,2'b00,1,0,0,0,0), 2'd0);
        expectCycle("rdy_mem2", ev(0,0,0,0,1,0,2'b00,1,0,0,0,0), 2'd0);
        expectCycle("rdy_mem3", ev(0,0,0,0,1,0,2'b00,1,0,0,0,0), 2'd0);
        memReady = 1'b1;
        expectCycle("rdy_mem4", ev(0,0,0,0,1,0,2'b00,1,0,0,1,0), 2'd0);
        expectCycle("rdy_next_fetch", ev(1,1,0,0,0,0,2'b00,0,0,0,0,0), 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
